fib_seq_gen: RTL and testbench

//  Parametrised successor of the single-result Fibonacci unit. Computes the generalised

---
 rtl/fib_pkg.sv | 12 +
 rtl/fib_add_sat.sv | 21 ++
 rtl/fib_seq_gen.sv | 165 ++++++++++++++++
 tb/tb_fib_seq_gen.sv | 319 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/fib_pkg.sv
// Shared types for the generalised Fibonacci sequence generator.
package fib_pkg;

  // Controller states: idle, computing, presenting a stream term, completion.
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    EMIT = 2'd2,
    FIN  = 2'd3
  } state_t;

endpackage

// File: rtl/fib_add_sat.sv
// fib_add_sat: combinational adder for the recurrence, with optional clamp on carry-out.
module fib_add_sat #(
  parameter int unsigned WIDTH    = 32,
  parameter int unsigned SATURATE = 0
) (
  input  logic [WIDTH-1:0] i_a,
  input  logic [WIDTH-1:0] i_b,
  output logic [WIDTH-1:0] o_sum,
  output logic             o_carry
);

  logic [WIDTH:0] w_full;

  // Full-width add; an overflowing sum clamps to all-ones when saturation is enabled.
  always_comb begin
    w_full  = {1'b0, i_a} + {1'b0, i_b};
    o_carry = w_full[WIDTH];
    o_sum   = ((SATURATE != 0) && w_full[WIDTH]) ? {WIDTH{1'b1}} : w_full[WIDTH-1:0];
  end

endmodule

// File: rtl/fib_seq_gen.sv
// fib_seq_gen: two-seed recurrence F(k)=F(k-1)+F(k-2) up to term n, returning F(n) only
// (result mode) or every term F(0..n) over a valid/ready stream (stream mode).
module fib_seq_gen
  import fib_pkg::*;
#(
  parameter int unsigned WIDTH    = 32,
  parameter int unsigned N_WIDTH  = 16,
  parameter int unsigned SATURATE = 0
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               i_start,
  input  logic               i_abort,
  input  logic               i_stream_mode,
  input  logic [N_WIDTH-1:0] i_n,
  input  logic [WIDTH-1:0]   i_seed0,
  input  logic [WIDTH-1:0]   i_seed1,
  output logic               o_busy,
  output logic               o_done,
  output logic [WIDTH-1:0]   o_result,
  output logic               o_overflow,
  output logic [WIDTH-1:0]   o_term,
  output logic [N_WIDTH-1:0] o_term_idx,
  output logic               o_term_valid,
  output logic               o_term_last,
  input  logic               i_term_ready
);

  state_t             r_state;
  logic [WIDTH-1:0]   r_a;
  logic [WIDTH-1:0]   r_b;
  logic [WIDTH-1:0]   r_result;
  logic [WIDTH-1:0]   r_term;
  logic [N_WIDTH-1:0] r_k;
  logic [N_WIDTH-1:0] r_n;
  logic [N_WIDTH-1:0] r_term_idx;
  logic               r_mode;
  logic               r_ovf;
  logic               r_done;
  logic               r_term_valid;
  logic               r_term_last;

  logic [WIDTH-1:0]   w_sum;
  logic               w_carry;
  logic               w_k_is_n;
  logic [N_WIDTH-1:0] w_k_next;
  logic [N_WIDTH:0]   w_k_plus2;
  logic               w_ovf_in_range;
  logic               w_handshake;

  fib_add_sat #(
    .WIDTH    (WIDTH),
    .SATURATE (SATURATE)
  ) u_add (
    .i_a     (r_a),
    .i_b     (r_b),
    .o_sum   (w_sum),
    .o_carry (w_carry)
  );

  // Index bookkeeping; k+2 is kept one bit wider so n at its maximum cannot wrap the compare.
  always_comb begin
    w_k_is_n       = (r_k == r_n);
    w_k_next       = r_k + N_WIDTH'(1);
    w_k_plus2      = {1'b0, r_k} + (N_WIDTH + 1)'(2);
    w_ovf_in_range = (w_k_plus2 <= {1'b0, r_n});
    w_handshake    = r_term_valid && i_term_ready;
  end

  // Controller, datapath registers and registered stream/result outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state      <= IDLE;
      r_a          <= '0;
      r_b          <= '0;
      r_k          <= '0;
      r_n          <= '0;
      r_mode       <= 1'b0;
      r_ovf        <= 1'b0;
      r_done       <= 1'b0;
      r_result     <= '0;
      r_term       <= '0;
      r_term_idx   <= '0;
      r_term_valid <= 1'b0;
      r_term_last  <= 1'b0;
    end else begin
      r_done <= 1'b0;
      if (r_state != IDLE && i_abort) begin
        // Abort cancels any running job, including the completion cycle: no done pulse.
        r_state      <= IDLE;
        r_term_valid <= 1'b0;
        r_term_last  <= 1'b0;
      end else begin
        case (r_state)
          IDLE: begin
            if (i_start && !i_abort) begin
              r_a      <= i_seed0;
              r_b      <= i_seed1;
              r_k      <= '0;
              r_n      <= i_n;
              r_mode   <= i_stream_mode;
              r_ovf    <= 1'b0;
              r_result <= '0;
              r_state  <= RUN;
            end
          end
          RUN: begin
            if (r_mode) begin
              r_term       <= r_a;
              r_term_idx   <= r_k;
              r_term_valid <= 1'b1;
              r_term_last  <= w_k_is_n;
              r_state      <= EMIT;
            end else if (w_k_is_n) begin
              r_result <= r_a;
              r_state  <= FIN;
            end else begin
              r_a <= r_b;
              r_b <= w_sum;
              r_k <= w_k_next;
              if (w_carry && w_ovf_in_range) r_ovf <= 1'b1;
            end
          end
          EMIT: begin
            if (w_handshake) begin
              if (w_k_is_n) begin
                r_result     <= r_a;
                r_term_valid <= 1'b0;
                r_term_last  <= 1'b0;
                r_state      <= FIN;
              end else begin
                // Advance and present the next term straight away (back-to-back).
                r_a         <= r_b;
                r_b         <= w_sum;
                r_k         <= w_k_next;
                r_term      <= r_b;
                r_term_idx  <= w_k_next;
                r_term_last <= (w_k_next == r_n);
                if (w_carry && w_ovf_in_range) r_ovf <= 1'b1;
              end
            end
          end
          FIN: begin
            r_done  <= 1'b1;
            r_state <= IDLE;
          end
          default: r_state <= IDLE;
        endcase
      end
    end
  end

  // Output mapping; busy covers FIN so it falls exactly when done rises.
  always_comb begin
    o_busy       = (r_state != IDLE);
    o_done       = r_done;
    o_result     = r_result;
    o_overflow   = r_ovf;
    o_term       = r_term;
    o_term_idx   = r_term_idx;
    o_term_valid = r_term_valid;
    o_term_last  = r_term_last;
  end

endmodule

// File: tb/tb_fib_seq_gen.sv
// Bench for fib_seq_gen: 32-bit wrap, 8-bit wrap and 8-bit saturating instances share stimulus.
module tb_fib_seq_gen;

  typedef struct packed {
    logic [31:0] val;
    logic        ovf;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic        abort = 1'b0;
  logic        stream_mode = 1'b0;
  logic        term_ready = 1'b0;
  logic [15:0] n = '0;
  logic [31:0] seed0 = '0;
  logic [31:0] seed1 = '0;

  logic        busy32, done32, ovf32, tv32, tl32;
  logic [31:0] result32, term32;
  logic [15:0] idx32;
  logic        busy8, done8, ovf8, tv8, tl8;
  logic [7:0]  result8, term8;
  logic [15:0] idx8;
  logic        busy8s, done8s, ovf8s, tv8s, tl8s;
  logic [7:0]  result8s, term8s;
  logic [15:0] idx8s;

  int n_checks = 0;
  int n_fail = 0;

  exp_t        q32[$];
  exp_t        q8[$];
  exp_t        q8s[$];
  logic [31:0] term_q[$];

  fib_seq_gen #(.WIDTH(32), .N_WIDTH(16), .SATURATE(0)) u_dut32 (
    .clk(clk), .rst_n(rst_n), .i_start(start), .i_abort(abort), .i_stream_mode(stream_mode),
    .i_n(n), .i_seed0(seed0), .i_seed1(seed1), .o_busy(busy32), .o_done(done32),
    .o_result(result32), .o_overflow(ovf32), .o_term(term32), .o_term_idx(idx32),
    .o_term_valid(tv32), .o_term_last(tl32), .i_term_ready(term_ready)
  );

  fib_seq_gen #(.WIDTH(8), .N_WIDTH(16), .SATURATE(0)) u_dut8 (
    .clk(clk), .rst_n(rst_n), .i_start(start), .i_abort(abort), .i_stream_mode(stream_mode),
    .i_n(n), .i_seed0(seed0[7:0]), .i_seed1(seed1[7:0]), .o_busy(busy8), .o_done(done8),
    .o_result(result8), .o_overflow(ovf8), .o_term(term8), .o_term_idx(idx8),
    .o_term_valid(tv8), .o_term_last(tl8), .i_term_ready(term_ready)
  );

  fib_seq_gen #(.WIDTH(8), .N_WIDTH(16), .SATURATE(1)) u_dut8s (
    .clk(clk), .rst_n(rst_n), .i_start(start), .i_abort(abort), .i_stream_mode(stream_mode),
    .i_n(n), .i_seed0(seed0[7:0]), .i_seed1(seed1[7:0]), .o_busy(busy8s), .o_done(done8s),
    .o_result(result8s), .o_overflow(ovf8s), .o_term(term8s), .o_term_idx(idx8s),
    .o_term_valid(tv8s), .o_term_last(tl8s), .i_term_ready(term_ready)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Reference recurrence at a given width; carries count only for terms with index <= n.
  function automatic exp_t model(input logic [31:0] s0, input logic [31:0] s1, input int nn,
                                 input int w, input bit sat);
    logic [63:0] a, b, s, mask;
    exp_t e;
    mask  = (64'd1 << w) - 64'd1;
    a     = {32'd0, s0} & mask;
    b     = {32'd0, s1} & mask;
    e.ovf = 1'b0;
    for (int k = 0; k < nn; k++) begin
      s = a + b;
      if (s > mask) begin
        if (k + 2 <= nn) e.ovf = 1'b1;
        s = sat ? mask : (s & mask);
      end
      a = b;
      b = s;
    end
    e.val = a[31:0];
    return e;
  endfunction

  // Called just after a rising edge; returns just after the edge that sampled start.
  task automatic start_job(input logic [31:0] s0, input logic [31:0] s1, input int nn,
                           input bit strm);
    seed0       = s0;
    seed1       = s1;
    n           = nn[15:0];
    stream_mode = strm;
    start       = 1'b1;
    @(posedge clk);
    #1;
    start       = 1'b0;
  endtask

  // Result-mode job on all three instances; poke>0 drives a junk start while busy.
  task automatic run_result(input logic [31:0] s0, input logic [31:0] s1, input int nn,
                            input string tag, input int poke);
    exp_t e;
    int   edges;
    bit   seen;
    edges = 0;
    seen  = 1'b0;
    q32.push_back(model(s0, s1, nn, 32, 1'b0));
    q8.push_back(model(s0, s1, nn, 8, 1'b0));
    q8s.push_back(model(s0, s1, nn, 8, 1'b1));
    start_job(s0, s1, nn, 1'b0);
    for (int i = 1; i <= nn + 10; i++) begin
      @(posedge clk);
      #1;
      if (i == poke) begin
        start       = 1'b1;
        seed0       = 32'hdead_beef;
        seed1       = 32'h0000_1234;
        n           = 16'd2;
        stream_mode = 1'b1;
      end else begin
        start       = 1'b0;
        stream_mode = 1'b0;
      end
      if (done32) begin
        edges = i;
        seen  = 1'b1;
        break;
      end
    end
    start       = 1'b0;
    stream_mode = 1'b0;
    check_eq({tag, "_done_seen"}, 64'(seen), 64'd1);
    check_eq({tag, "_latency"}, 64'(edges), 64'(nn + 2));
    check_eq({tag, "_busy_at_done"}, 64'(busy32), 64'd0);
    check_eq({tag, "_done8"}, {62'd0, done8, done8s}, 64'd3);
    e = q32.pop_front();
    check_eq({tag, "_result32"}, 64'(result32), 64'(e.val));
    check_eq({tag, "_ovf32"}, 64'(ovf32), 64'(e.ovf));
    e = q8.pop_front();
    check_eq({tag, "_result8"}, 64'(result8), 64'(e.val));
    check_eq({tag, "_ovf8"}, 64'(ovf8), 64'(e.ovf));
    e = q8s.pop_front();
    check_eq({tag, "_result8s"}, 64'(result8s), 64'(e.val));
    check_eq({tag, "_ovf8s"}, 64'(ovf8s), 64'(e.ovf));
    @(posedge clk);
    #1;
    check_eq({tag, "_done_one_cycle"}, 64'(done32), 64'd0);
  endtask

  // Stream-mode job on the 32-bit instance with random back-pressure.
  task automatic run_stream(input logic [31:0] s0, input logic [31:0] s1, input int nn);
    logic [31:0] a, b, s, exp_term, h_term;
    logic [15:0] h_idx;
    logic        h_last;
    bit          stalled, seen;
    int          ei;
    a = s0;
    b = s1;
    for (int k = 0; k <= nn; k++) begin
      term_q.push_back(a);
      s = a + b;
      a = b;
      b = s;
    end
    stalled    = 1'b0;
    seen       = 1'b0;
    ei         = 0;
    h_term     = '0;
    h_idx      = '0;
    h_last     = 1'b0;
    term_ready = 1'b0;
    start_job(s0, s1, nn, 1'b1);
    for (int c = 0; c < 200 && !seen; c++) begin
      @(negedge clk);
      if (done32) begin
        seen = 1'b1;
      end else if (tv32) begin
        if (stalled) begin
          check_eq("stall_term", 64'(term32), 64'(h_term));
          check_eq("stall_idx", 64'(idx32), 64'(h_idx));
          check_eq("stall_last", 64'(tl32), 64'(h_last));
        end
        if (term_ready) begin
          exp_term = (term_q.size() > 0) ? term_q.pop_front() : 32'hffff_ffff;
          check_eq("stream_term", 64'(term32), 64'(exp_term));
          check_eq("stream_idx", 64'(idx32), 64'(ei));
          check_eq("stream_last", 64'(tl32), 64'(ei == nn));
          ei++;
          stalled = 1'b0;
        end else begin
          h_term  = term32;
          h_idx   = idx32;
          h_last  = tl32;
          stalled = 1'b1;
        end
      end
      @(posedge clk);
      #1;
      term_ready = 1'($urandom_range(0, 1));
    end
    term_ready  = 1'b0;
    stream_mode = 1'b0;
    check_eq("stream_done_seen", 64'(seen), 64'd1);
    check_eq("stream_terms_left", 64'(term_q.size()), 64'd0);
    check_eq("stream_count", 64'(ei), 64'(nn + 1));
    check_eq("stream_valid_after", 64'(tv32), 64'd0);
    check_eq("stream_result", 64'(result32), 64'(model(s0, s1, nn, 32, 1'b0).val));
  endtask

  initial begin
    bit done_seen;
    // Reset values before any clock edge.
    #3;
    check_eq("rst_busy", 64'(busy32), 64'd0);
    check_eq("rst_done", 64'(done32), 64'd0);
    check_eq("rst_ovf", 64'(ovf32), 64'd0);
    check_eq("rst_valid", 64'(tv32), 64'd0);
    check_eq("rst_last", 64'(tl32), 64'd0);
    check_eq("rst_result", 64'(result32), 64'd0);
    check_eq("rst_term", 64'(term32), 64'd0);
    check_eq("rst_idx", 64'(idx32), 64'd0);
    #19 rst_n = 1'b1;
    @(posedge clk);
    #1;

    run_result(32'd0, 32'd1, 10, "fib10", -1);
    check_eq("fib10_value", 64'(result32), 64'd55);
    run_result(32'd5, 32'd9, 0, "n0", -1);
    check_eq("n0_value", 64'(result32), 64'd5);
    run_result(32'd5, 32'd9, 1, "n1", -1);
    check_eq("n1_value", 64'(result32), 64'd9);
    run_result(32'd2, 32'd1, 5, "lucas5", -1);
    check_eq("lucas5_value", 64'(result32), 64'd11);
    run_result(32'd0, 32'd1, 13, "w8_n13", -1);
    check_eq("w8_n13_value", {48'd0, result8, 7'd0, ovf8}, {48'd0, 8'd233, 8'd0});
    run_result(32'd0, 32'd1, 14, "w8_n14", -1);
    check_eq("w8_n14_wrap", {48'd0, result8, 7'd0, ovf8}, {48'd0, 8'd121, 8'd1});
    check_eq("w8_n14_sat", {48'd0, result8s, 7'd0, ovf8s}, {48'd0, 8'd255, 8'd1});
    // Carry on F(2): counted when n=2, ignored when F(2) lies beyond n=1.
    run_result(32'h8000_0000, 32'h8000_0000, 2, "ovf_in", -1);
    check_eq("ovf_in_flag", 64'(ovf32), 64'd1);
    run_result(32'h8000_0000, 32'h8000_0000, 1, "ovf_beyond", -1);
    check_eq("ovf_beyond_flag", 64'(ovf32), 64'd0);

    run_stream(32'd0, 32'd1, 4);
    @(posedge clk);
    #1;

    // Abort at k=3 of an n=20 job; start already cleared result to 0 and abort leaves it.
    start_job(32'd0, 32'd1, 20, 1'b0);
    repeat (3) @(posedge clk);
    #1;
    abort = 1'b1;
    @(posedge clk);
    #1;
    abort = 1'b0;
    check_eq("abort_busy", 64'(busy32), 64'd0);
    check_eq("abort_done", 64'(done32), 64'd0);
    check_eq("abort_result", 64'(result32), 64'd0);
    done_seen = 1'b0;
    repeat (25) begin
      @(posedge clk);
      #1;
      if (done32) done_seen = 1'b1;
    end
    check_eq("abort_no_done", 64'(done_seen), 64'd0);

    // Abort and start together in IDLE: start is dropped.
    seed0 = 32'd3;
    seed1 = 32'd4;
    n     = 16'd3;
    start = 1'b1;
    abort = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    abort = 1'b0;
    check_eq("abort_start_busy", 64'(busy32), 64'd0);

    run_result(32'd0, 32'd1, 10, "busy_start", 3);
    check_eq("busy_start_value", 64'(result32), 64'd55);

    // Asynchronous reset mid-stream.
    term_ready = 1'b1;
    start_job(32'd0, 32'd1, 10, 1'b1);
    repeat (5) @(posedge clk);
    #2;
    check_eq("pre_rst_valid", 64'(tv32), 64'd1);
    rst_n = 1'b0;
    #1;
    check_eq("arst_busy", 64'(busy32), 64'd0);
    check_eq("arst_valid", 64'(tv32), 64'd0);
    check_eq("arst_last", 64'(tl32), 64'd0);
    check_eq("arst_term", 64'(term32), 64'd0);
    check_eq("arst_idx", 64'(idx32), 64'd0);
    check_eq("arst_done_ovf_res", {31'd0, done32, ovf32, result32}, 64'd0);
    term_ready  = 1'b0;
    stream_mode = 1'b0;
    #3 rst_n = 1'b1;
    @(posedge clk);
    #1;
    run_result(32'd2, 32'd1, 7, "post_rst", -1);
    check_eq("post_rst_value", 64'(result32), 64'd29);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "bench timed out");
  end

endmodule
